// File: rtl/io_pkg.sv
// Shared definitions for the CPU-side IO handshake blocks (input and output buffers).
package io_pkg;
  localparam int IO_WIDTH = 16;

  typedef enum logic [1:0] {
    IO_IDLE     = 2'd0,
    IO_ACK      = 2'd1,
    IO_WAIT_LOW = 2'd2
  } io_state_t;
endpackage

// File: rtl/io_input_buffer_if.sv
// Producer push port plus CPU input-port handshake, grouped as one bus.
interface io_input_buffer_if
  import io_pkg::*;
#(
  parameter int WIDTH  = IO_WIDTH,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              inp_req;
  logic              inp_ack;
  logic [WIDTH-1:0]  inp_data;

  modport master (
    output wr_en, wr_data, inp_req,
    input  full, empty, count, overflow, inp_ack, inp_data
  );

  modport slave (
    input  wr_en, wr_data, inp_req,
    output full, empty, count, overflow, inp_ack, inp_data
  );
endinterface

// File: rtl/io_input_buffer_fifo_ram.sv
// FIFO storage: register array, synchronous write, combinational read.
module fifo_ram
  import io_pkg::*;
#(
  parameter int WIDTH  = IO_WIDTH,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/io_input_buffer.sv
// Circular FIFO feeding the CPU input port; one word per request, one-cycle ack,
// then waits for the request to drop so a held inp_req cannot pop twice.
module io_input_buffer
  import io_pkg::*;
#(
  parameter int WIDTH  = IO_WIDTH,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic              clk,
  input logic              rst,
  io_input_buffer_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf, r_ack;
  logic [WIDTH-1:0]  r_data;
  io_state_t         r_state;

  logic              w_full, w_empty, w_push, w_pop;
  logic [WIDTH-1:0]  w_rdata;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Push decision uses the pre-edge count: a pop in the same cycle does not make room.
  assign w_push  = bus.wr_en && !w_full;
  assign w_pop   = (r_state == IO_IDLE) && bus.inp_req && !w_empty;

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_ack    <= 1'b0;
      r_data   <= '0;
      r_state  <= IO_IDLE;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (bus.wr_en && w_full) r_ovf <= 1'b1;

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      unique case (r_state)
        IO_IDLE: begin
          if (w_pop) begin
            r_data   <= w_rdata;
            r_ack    <= 1'b1;
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_state  <= IO_ACK;
          end else begin
            r_ack    <= 1'b0;
          end
        end
        IO_ACK: begin
          r_ack   <= 1'b0;
          r_state <= bus.inp_req ? IO_WAIT_LOW : IO_IDLE;
        end
        IO_WAIT_LOW: begin
          if (!bus.inp_req) r_state <= IO_IDLE;
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= IO_IDLE;
        end
      endcase
    end
  end

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = r_count;
  assign bus.overflow = r_ovf;
  assign bus.inp_ack  = r_ack;
  assign bus.inp_data = r_data;
endmodule

// File: tb/tb_io_input_buffer.sv
// Directed scenarios plus random traffic against a queue-based model of the buffer.
module tb_io_input_buffer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_input_buffer_if bus ();
  io_input_buffer dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Model: word queue, sticky overflow, last delivered word, ack/handshake phase.
  logic [15:0] q[$];
  bit          m_ack, m_need_low, m_ovf;
  logic [15:0] m_data;

  task automatic cyc(input bit we, input logic [15:0] wd, input bit rq, input bit rs = 1'b0);
    int pre;
    rst = rs; bus.wr_en = we; bus.wr_data = wd; bus.inp_req = rq;
    @(posedge clk);
    if (rs) begin
      q.delete(); m_ack = 0; m_need_low = 0; m_ovf = 0; m_data = '0;
    end else begin
      pre = q.size();
      if (m_ack) begin
        m_ack = 0; m_need_low = rq;
      end else if (m_need_low) begin
        if (!rq) m_need_low = 0;
      end else if (rq && pre > 0) begin
        m_data = q.pop_front(); m_ack = 1;
      end
      if (we) begin
        if (pre < DEPTH) q.push_back(wd);
        else m_ovf = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 16'h0, 0, 1);
    checks += 6;
    if (bus.count !== 4'd0)     begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    if (bus.empty !== 1'b1)     begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    if (bus.full !== 1'b0)      begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    if (bus.overflow !== 1'b0)  begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    if (bus.inp_ack !== 1'b0)   begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.inp_ack); end
    if (bus.inp_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", bus.inp_data); end
  endtask

  task automatic test_single();
    cyc(1, 16'h0042, 0);
    cyc(0, 16'h0, 0);
    cyc(0, 16'h0, 0);
    checks++;
    if (bus.count !== 4'd1) begin failures++; $display("FAIL single_count_pre got=%0d exp=1", bus.count); end
    cyc(0, 16'h0, 1);
    checks += 4;
    if (bus.inp_ack !== 1'b1)      begin failures++; $display("FAIL single_ack got=%b exp=1", bus.inp_ack); end
    if (bus.inp_data !== 16'h0042) begin failures++; $display("FAIL single_data got=%h exp=0042", bus.inp_data); end
    if (bus.count !== 4'd0)        begin failures++; $display("FAIL single_count got=%0d exp=0", bus.count); end
    if (bus.empty !== 1'b1)        begin failures++; $display("FAIL single_empty got=%b exp=1", bus.empty); end
    cyc(0, 16'h0, 0);
    checks += 2;
    if (bus.inp_ack !== 1'b0)      begin failures++; $display("FAIL single_ack_drop got=%b exp=0", bus.inp_ack); end
    if (bus.inp_data !== 16'h0042) begin failures++; $display("FAIL single_data_hold got=%h exp=0042", bus.inp_data); end
  endtask

  task automatic test_held_request();
    int acks = 0;
    logic [15:0] first = '0;
    cyc(1, 16'h0001, 0);
    cyc(1, 16'h0002, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 16'h0, 1);
      if (bus.inp_ack === 1'b1) begin acks++; if (acks == 1) first = bus.inp_data; end
    end
    checks += 3;
    if (acks != 1)             begin failures++; $display("FAIL held_ack_count got=%0d exp=1", acks); end
    if (first !== 16'h0001)    begin failures++; $display("FAIL held_data got=%h exp=0001", first); end
    if (bus.count !== 4'd1)    begin failures++; $display("FAIL held_count got=%0d exp=1", bus.count); end
    cyc(0, 16'h0, 0);
    cyc(0, 16'h0, 1);
    checks += 2;
    if (bus.inp_ack !== 1'b1)      begin failures++; $display("FAIL held_second_ack got=%b exp=1", bus.inp_ack); end
    if (bus.inp_data !== 16'h0002) begin failures++; $display("FAIL held_second_data got=%h exp=0002", bus.inp_data); end
    cyc(0, 16'h0, 0);
  endtask

  task automatic test_empty_stall();
    int acks = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 16'h0, 1);
      if (bus.inp_ack === 1'b1) acks++;
    end
    cyc(1, 16'hBEEF, 1);
    if (bus.inp_ack === 1'b1) acks++;
    checks++;
    if (acks != 0) begin failures++; $display("FAIL stall_early_ack got=%0d exp=0", acks); end
    cyc(0, 16'h0, 1);
    checks += 2;
    if (bus.inp_ack !== 1'b1)      begin failures++; $display("FAIL stall_ack got=%b exp=1", bus.inp_ack); end
    if (bus.inp_data !== 16'hBEEF) begin failures++; $display("FAIL stall_data got=%h exp=beef", bus.inp_data); end
    cyc(0, 16'h0, 0);
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 9; i++) cyc(1, 16'(i), 0);
    checks += 3;
    if (bus.full !== 1'b1)     begin failures++; $display("FAIL ovf_full got=%b exp=1", bus.full); end
    if (bus.count !== 4'd8)    begin failures++; $display("FAIL ovf_count got=%0d exp=8", bus.count); end
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 16'h0, 1);
      checks++;
      if (bus.inp_ack !== 1'b1 || bus.inp_data !== 16'(i))
        begin failures++; $display("FAIL drain_%0d got ack=%b data=%h exp ack=1 data=%h", i, bus.inp_ack, bus.inp_data, 16'(i)); end
      cyc(0, 16'h0, 0);
    end
    checks += 2;
    if (bus.empty !== 1'b1)    begin failures++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_simultaneous();
    cyc(0, 16'h0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 16'h0010 + 16'(i), 0);
    cyc(1, 16'h0013, 1);
    checks += 2;
    if (bus.count !== 4'd3)        begin failures++; $display("FAIL simul_count got=%0d exp=3", bus.count); end
    if (bus.inp_data !== 16'h0010) begin failures++; $display("FAIL simul_data got=%h exp=0010", bus.inp_data); end
    cyc(0, 16'h0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 16'h0020 + 16'(i), 0);
    checks += 2;
    if (bus.full !== 1'b1)     begin failures++; $display("FAIL simul_full got=%b exp=1", bus.full); end
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL simul_ovf_pre got=%b exp=0", bus.overflow); end
    cyc(1, 16'h0099, 1);
    checks += 3;
    if (bus.count !== 4'd7)        begin failures++; $display("FAIL full_pushpop_count got=%0d exp=7", bus.count); end
    if (bus.overflow !== 1'b1)     begin failures++; $display("FAIL full_pushpop_ovf got=%b exp=1", bus.overflow); end
    if (bus.inp_data !== 16'h0011) begin failures++; $display("FAIL full_pushpop_data got=%h exp=0011", bus.inp_data); end
    cyc(0, 16'h0, 0);
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    cyc(0, 16'h0, 0, 1);
    cyc(1, 16'hAAAA, 0);
    cyc(1, 16'hBBBB, 1);
    checks++;
    if (bus.inp_ack !== 1'b1) begin failures++; $display("FAIL mid_ack_pre got=%b exp=1", bus.inp_ack); end
    cyc(0, 16'h0, 1, 1);
    checks += 3;
    if (bus.inp_ack !== 1'b0)   begin failures++; $display("FAIL mid_ack got=%b exp=0", bus.inp_ack); end
    if (bus.inp_data !== 16'h0) begin failures++; $display("FAIL mid_data got=%h exp=0000", bus.inp_data); end
    if (bus.count !== 4'd0)     begin failures++; $display("FAIL mid_count got=%0d exp=0", bus.count); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 16'h0, 1);
      if (bus.inp_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin failures++; $display("FAIL mid_empty_ack got=%0d exp=0", acks); end
    cyc(0, 16'h0, 0);
  endtask

  task automatic test_random();
    bit rq = 0;
    cyc(0, 16'h0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) rq = !rq;
      cyc(($urandom_range(0, 9) < 5), 16'($urandom), rq, ($urandom_range(0, 199) == 0));
      checks += 6;
      if (bus.inp_ack !== m_ack)
        begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", n, bus.inp_ack, m_ack); end
      if (bus.inp_data !== m_data)
        begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, bus.inp_data, m_data); end
      if (bus.count !== 4'(q.size()))
        begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, bus.count, q.size()); end
      if (bus.full !== (q.size() == DEPTH))
        begin failures++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", n, bus.full, q.size() == DEPTH); end
      if (bus.empty !== (q.size() == 0))
        begin failures++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", n, bus.empty, q.size() == 0); end
      if (bus.overflow !== m_ovf)
        begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", n, bus.overflow, m_ovf); end
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.inp_req = 1'b0;
    test_reset();
    test_single();
    test_held_request();
    test_empty_stall();
    test_full_overflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_input_buffer.md
Name: io_input_buffer

Overview:
- Input-side peripheral that feeds the CPU's input port (inp_req/inp_ack/inp_data) during IN-class instructions.
- An external producer pushes 16-bit words into an internal circular FIFO.
- The block answers each CPU input request with one word and a one-cycle acknowledge, then waits for the request to drop before serving again. This prevents double-pops while the CPU's control unit is still holding inp_req.

Parameters:
- WIDTH, 16, data word width; must match the CPU datapath.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ADDR_W, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_en  input  1  producer push strobe, sampled every cycle.
- wr_data  input  WIDTH  producer word, captured when a push is accepted.
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds 0 words.
- count  output  ADDR_W+1  number of words stored, 0..DEPTH.
- overflow  output  1  sticky; set when a push is dropped.
- inp_req  input  1  CPU input request; level signal, held until the CPU sees inp_ack.
- inp_ack  output  1  one-cycle acknowledge; inp_data is valid while it is high.
- inp_data  output  WIDTH  word delivered to the CPU.

Behaviour:
Reset (synchronous, active-high):
- Read and write pointers = 0; count = 0; empty = 1; full = 0; overflow = 0; inp_ack = 0; inp_data = 0; state = IDLE.
- Reset wins over every other event in the same cycle. A reset asserted while in ACK or WAIT_LOW discards the pending handshake, and the FIFO contents are lost.

Push:
- A push is accepted when wr_en = 1 and full = 0, evaluated on the pre-edge count.
- On acceptance: mem[wr_ptr] <= wr_data; wr_ptr increments, wrapping modulo DEPTH.
- A push while full is dropped and sets overflow. This applies even if a pop happens in the same cycle; no bypass is provided.
- overflow clears only on reset.

Pop (CPU side), state machine with states IDLE, ACK, WAIT_LOW:
- IDLE: if inp_req = 1 and empty = 0, then at the next edge: inp_data <= mem[rd_ptr]; inp_ack <= 1; rd_ptr increments (wrapping); go to ACK. Otherwise stay in IDLE and keep inp_ack = 0.
- ACK: inp_ack <= 0 at the next edge. If inp_req = 1, go to WAIT_LOW; otherwise go to IDLE.
- WAIT_LOW: stay until inp_req = 0, then go to IDLE. No pop happens in this state.
- Latency: from inp_req first sampled high with data present to inp_ack high is 1 cycle.
- If inp_req is high while the FIFO is empty, the block stalls in IDLE. The ack follows one cycle after the first edge at which count > 0. A word pushed at edge N can therefore be acked at edge N+1 at the earliest.
- inp_data is registered and holds its last delivered value until the next ack. It never changes outside an ack cycle.

Count, flags and arithmetic:
- count changes by +1 for a push only, -1 for a pop only, 0 for both or neither.
- A simultaneous push and pop with 0 < count < DEPTH is legal, and count is unchanged.
- full = (count == DEPTH); empty = (count == 0). Both are derived from registered count, so they are glitch-free.
- Pointers are ADDR_W bits and wrap naturally; count is ADDR_W+1 bits to distinguish full from empty.
- A dropping of inp_req by the CPU in IDLE before it is served is legal; nothing is popped.

Decomposition:
- Shared package io_pkg: localparam IO_WIDTH = 16; the state encoding IO_IDLE = 2'd0, IO_ACK = 2'd1, IO_WAIT_LOW = 2'd2. A mirror output-side block will reuse these.
- One sub-module: fifo_ram, a DEPTH x WIDTH register array with synchronous write and combinational read, indexed by the pointers.
- The FSM, pointers and count stay in io_input_buffer.

Test Plan:
- Reset then single word: push 16'h0042; raise inp_req 2 cycles later -> inp_ack high exactly 1 cycle after req is sampled, inp_data = 16'h0042, count goes 1 to 0, empty = 1.
- Held request: keep inp_req high 4 cycles after the ack with 16'h0001 and 16'h0002 queued -> exactly one ack with data 16'h0001; the second ack (16'h0002) comes only after inp_req drops and rises again.
- Empty stall: raise inp_req with count = 0 for 5 cycles, then push 16'hBEEF at edge N -> inp_ack at edge N+1 with inp_data = 16'hBEEF; no earlier ack.
- Full and overflow: push 9 words 16'h0000..16'h0008 with DEPTH = 8 -> full = 1, count = 8, overflow = 1. Draining 8 times returns 16'h0000..16'h0007 in order, including across pointer wrap.
- Simultaneous push and pop at count = 3 -> count stays 3. At count = 8, push plus pop -> push dropped, count = 7, overflow = 1.
- Reset mid-handshake: assert rst in the ACK cycle -> next cycle inp_ack = 0, inp_data = 0, count = 0, state = IDLE; a following request with the FIFO empty gets no ack.
